// File: rtl/tx_pkg.sv
// Shared definitions for the PRBS transmitter: LFSR geometry, per-channel seeds
// and the capture FSM state encoding.
package tx_pkg;

   localparam int PRBS_ORDER = 9;
   localparam int TAP_HI     = 8;
   localparam int TAP_LO     = 4;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CAPTURE = 2'd1,
      ST_DONE    = 2'd2
   } cap_state_t;

   // Distinct per channel and never zero for channel indices up to 255.
   function automatic logic [PRBS_ORDER-1:0] seed(input int c);
      return 9'h1FF ^ PRBS_ORDER'(c << 1);
   endfunction

endpackage

// File: rtl/prbs_lfsr.sv
// One PRBS9 channel (x^9 + x^5 + 1) with a registered output bit that updates
// only when advanced.
module prbs_lfsr
   import tx_pkg::*;
#(
   parameter logic [PRBS_ORDER-1:0] SEED = 9'h1FF
) (
   input  logic clock,
   input  logic reset,
   input  logic advance,
   output logic prbs_bit
);

   logic [PRBS_ORDER-1:0] r;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of its neighbours.
   always_ff @(posedge clock) begin
      if (reset) begin
         r        <= SEED;
         prbs_bit <= 1'b0;
      end else begin
         // An all-zero register would stick forever; pull it back to the seed.
         if (r == '0)
            r <= SEED;
         else if (advance)
            r <= {r[PRBS_ORDER-2:0], r[TAP_HI] ^ r[TAP_LO]};
         if (advance)
            prbs_bit <= r[TAP_HI];
      end
   end

endmodule

// File: rtl/tx_prbs_capture.sv
// Multi-channel PRBS9 transmitter with a programmable strobe divider and a
// capture RAM that records a burst of consecutive valid samples for read-back.
module tx_prbs_capture
   import tx_pkg::*;
#(
   parameter int NB_COUNT      = 3,
   parameter int NUM_CH        = 4,
   parameter int CAPTURE_DEPTH = 1024,
   parameter int NB_ADDR       = 10
) (
   input  logic                clock,
   input  logic                i_reset,
   input  logic [3:0]          i_enable,
   input  logic [NB_COUNT-1:0] i_rate,
   input  logic                i_start,
   input  logic [NB_ADDR-1:0]  i_rd_addr,
   output logic [3:0]          o_leds,
   output logic [NUM_CH-1:0]   o_data,
   output logic                o_valid,
   output logic                o_busy,
   output logic                o_done,
   output logic [NUM_CH-1:0]   o_rd_data
);

   logic [NB_COUNT-1:0] count;
   logic                tick;
   logic                advance;
   cap_state_t          state;
   logic [NB_ADDR-1:0]  wr_addr;
   logic                wr_en;
   logic [NUM_CH-1:0]   mem [CAPTURE_DEPTH];

   assign o_leds = i_enable;

   // >= rather than == so lowering i_rate below count fires on the next cycle.
   assign tick    = i_enable[0] && (count >= i_rate);
   assign advance = tick && i_enable[1];

   always_ff @(posedge clock) begin
      if (i_reset)
         count <= '0;
      else if (tick)
         count <= '0;
      else if (i_enable[0])
         count <= count + 1'b1;
   end

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      prbs_lfsr #(
         .SEED(seed(c))
      ) u_lfsr (
         .clock    (clock),
         .reset    (i_reset),
         .advance  (advance),
         .prbs_bit (o_data[c])
      );
   end

   always_ff @(posedge clock) begin
      if (i_reset)
         o_valid <= 1'b0;
      else
         o_valid <= advance;
   end

   always_ff @(posedge clock) begin
      if (i_reset) begin
         state   <= ST_IDLE;
         wr_addr <= '0;
         o_busy  <= 1'b0;
         o_done  <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (i_start && i_enable[2]) begin
                  state   <= ST_CAPTURE;
                  wr_addr <= '0;
                  o_busy  <= 1'b1;
               end
            end
            ST_CAPTURE: begin
               if (!i_enable[2]) begin
                  state   <= ST_IDLE;
                  wr_addr <= '0;
                  o_busy  <= 1'b0;
               end else if (o_valid) begin
                  wr_addr <= wr_addr + 1'b1;
                  if (wr_addr == NB_ADDR'(CAPTURE_DEPTH - 1)) begin
                     state  <= ST_DONE;
                     o_busy <= 1'b0;
                     o_done <= 1'b1;
                  end
               end
            end
            ST_DONE: begin
               if (i_start && i_enable[2]) begin
                  state   <= ST_CAPTURE;
                  wr_addr <= '0;
                  o_busy  <= 1'b1;
                  o_done  <= 1'b0;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // An abort or a reset on the same edge suppresses the write.
   assign wr_en = (state == ST_CAPTURE) && i_enable[2] && o_valid && !i_reset;

   // NOTE: the RAM has no reset so it maps onto block memory and keeps
   // captured data across a reset.
   always_ff @(posedge clock) begin
      if (wr_en)
         mem[wr_addr] <= o_data;
   end

   always_ff @(posedge clock) begin
      if (i_reset)
         o_rd_data <= '0;
      else
         o_rd_data <= mem[i_rd_addr];
   end

endmodule

// File: tb/tb_tx_prbs_capture.sv
// Directed bench for tx_prbs_capture: table-driven divider/PRBS vectors plus
// hand-written capture, abort, gating and reset sequences.
module tb_tx_prbs_capture;

   localparam int NB_COUNT = 3;
   localparam int NUM_CH   = 4;
   localparam int DEPTH    = 16;
   localparam int NB_ADDR  = 4;

   logic                clock;
   logic                i_reset;
   logic [3:0]          i_enable;
   logic [NB_COUNT-1:0] i_rate;
   logic                i_start;
   logic [NB_ADDR-1:0]  i_rd_addr;
   logic [3:0]          o_leds;
   logic [NUM_CH-1:0]   o_data;
   logic                o_valid;
   logic                o_busy;
   logic                o_done;
   logic [NUM_CH-1:0]   o_rd_data;

   tx_prbs_capture #(
      .NB_COUNT      (NB_COUNT),
      .NUM_CH        (NUM_CH),
      .CAPTURE_DEPTH (DEPTH),
      .NB_ADDR       (NB_ADDR)
   ) dut (
      .clock     (clock),
      .i_reset   (i_reset),
      .i_enable  (i_enable),
      .i_rate    (i_rate),
      .i_start   (i_start),
      .i_rd_addr (i_rd_addr),
      .o_leds    (o_leds),
      .o_data    (o_data),
      .o_valid   (o_valid),
      .o_busy    (o_busy),
      .o_done    (o_done),
      .o_rd_data (o_rd_data)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int n_checks = 0;
   int n_fail   = 0;

   // First PRBS bits after reseed, hand-derived from the seeds 1FF and 1FD.
   bit ch0_exp [16] = '{1,1,1,1,1,1,1,1,1,0,0,0,0,0,1,1};
   bit ch1_exp [10] = '{1,1,1,1,1,1,1,0,1,0};

   typedef struct {
      logic [2:0] rate;
      logic [3:0] en;
      int         gap;      // expected cycles between strobes, 0 = none
      int         n_valid;  // expected strobes in 24 cycles
   } vec_t;

   vec_t vecs [7];

   logic [8:0]        m_r [NUM_CH];
   logic [NUM_CH-1:0] exp_mem [DEPTH];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [8:0] m_seed(input int c);
      return 9'h1FF ^ 9'(c * 2);
   endfunction

   // One clock; sample #1 after the edge and keep the reference PRBS in step.
   task automatic step();
      logic              rst_edge;
      logic [NUM_CH-1:0] exp_bits;
      rst_edge = i_reset;
      @(posedge clock);
      #1;
      if (rst_edge) begin
         for (int c = 0; c < NUM_CH; c++) m_r[c] = m_seed(c);
      end else if (o_valid) begin
         for (int c = 0; c < NUM_CH; c++) begin
            exp_bits[c] = m_r[c][8];
            m_r[c] = {m_r[c][7:0], m_r[c][8] ^ m_r[c][4]};
         end
         check("prbs_model", 32'(o_data), 32'(exp_bits));
      end
   endtask

   task automatic do_reset();
      i_reset  = 1'b1;
      i_enable = 4'b0000;
      i_start  = 1'b0;
      step();
      i_reset = 1'b0;
   endtask

   task automatic read_check(input int addr, input logic [NUM_CH-1:0] exp, input string name);
      i_rd_addr = NB_ADDR'(addr);
      step();
      check($sformatf("%s[%0d]", name, addr), 32'(o_rd_data), 32'(exp));
   endtask

   // Pulse i_start and follow n_wr RAM writes, mirroring them into exp_mem.
   task automatic capture(input int n_wr);
      int                w;
      int                guard;
      logic              pend;
      logic [NUM_CH-1:0] pend_data;
      i_start = 1'b1;
      step();
      i_start = 1'b0;
      check("start_busy", 32'(o_busy), 32'd1);
      w = 0;
      guard = 0;
      while (w < n_wr && guard < 100) begin
         pend      = o_busy && o_valid;
         pend_data = o_data;
         step();
         if (pend) begin
            exp_mem[w] = pend_data;
            w++;
         end
         guard++;
      end
      check("capture_writes", 32'(w), 32'(n_wr));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int nv, first, last, gap_err;

      vecs[0] = '{3'd3, 4'b0011, 4, 6};
      vecs[1] = '{3'd0, 4'b0011, 1, 24};
      vecs[2] = '{3'd5, 4'b0011, 6, 4};
      vecs[3] = '{3'd7, 4'b0011, 8, 3};
      vecs[4] = '{3'd1, 4'b0011, 2, 12};
      vecs[5] = '{3'd2, 4'b0001, 0, 0};
      vecs[6] = '{3'd2, 4'b0010, 0, 0};

      i_reset   = 1'b1;
      i_enable  = 4'b0000;
      i_rate    = '0;
      i_start   = 1'b0;
      i_rd_addr = '0;
      for (int c = 0; c < NUM_CH; c++) m_r[c] = m_seed(c);
      step();
      step();
      check("rst_data",  32'(o_data),    32'd0);
      check("rst_valid", 32'(o_valid),   32'd0);
      check("rst_busy",  32'(o_busy),    32'd0);
      check("rst_done",  32'(o_done),    32'd0);
      check("rst_rd",    32'(o_rd_data), 32'd0);
      i_reset = 1'b0;

      // Divider and PRBS vectors.
      for (int v = 0; v < 7; v++) begin
         do_reset();
         i_rate   = vecs[v].rate;
         i_enable = vecs[v].en;
         nv = 0; first = 0; last = 0; gap_err = 0;
         for (int e = 1; e <= 24; e++) begin
            step();
            if (o_valid) begin
               if (nv == 0) first = e;
               else if (e - last != vecs[v].gap) gap_err++;
               last = e;
               if (nv < 16) check($sformatf("v%0d_ch0_bit%0d", v, nv), 32'(o_data[0]), 32'(ch0_exp[nv]));
               if (nv < 10) check($sformatf("v%0d_ch1_bit%0d", v, nv), 32'(o_data[1]), 32'(ch1_exp[nv]));
               nv++;
            end
         end
         check($sformatf("v%0d_leds", v),    32'(o_leds), 32'(vecs[v].en));
         check($sformatf("v%0d_n_valid", v), 32'(nv),     32'(vecs[v].n_valid));
         check($sformatf("v%0d_first", v),   32'(first),  32'(vecs[v].gap));
         check($sformatf("v%0d_gap_err", v), 32'(gap_err), 32'd0);
      end

      // Rate lowered from 7 to 2 while count is 5: strobes at cycles 6, 9, 12.
      do_reset();
      i_rate   = 3'd7;
      i_enable = 4'b0011;
      for (int e = 1; e <= 12; e++) begin
         step();
         check($sformatf("dyn_valid_c%0d", e), 32'(o_valid), 32'((e == 6) || (e == 9) || (e == 12)));
         if (e == 5) i_rate = 3'd2;
      end

      // PRBS gated off with the divider running: no strobe, data frozen.
      begin
         logic [NUM_CH-1:0] frozen;
         do_reset();
         i_rate   = 3'd0;
         i_enable = 4'b0011;
         repeat (5) step();
         frozen   = o_data;
         i_enable = 4'b0001;
         for (int e = 0; e < 4; e++) begin
            step();
            check("gate_valid", 32'(o_valid), 32'd0);
            check("gate_data",  32'(o_data),  32'(frozen));
         end
      end

      // Divider disabled at count 2 must resume from 2, not restart.
      do_reset();
      i_rate   = 3'd3;
      i_enable = 4'b0011;
      repeat (2) step();
      i_enable = 4'b0010;
      for (int e = 0; e < 5; e++) begin
         step();
         check("freeze_valid", 32'(o_valid), 32'd0);
      end
      check("freeze_leds", 32'(o_leds), 32'b0010);
      i_enable = 4'b0011;
      step();
      check("resume_valid_1", 32'(o_valid), 32'd0);
      step();
      check("resume_valid_2", 32'(o_valid), 32'd1);

      // Full capture at rate 0.
      do_reset();
      i_rate   = 3'd0;
      i_enable = 4'b0111;
      capture(DEPTH);
      check("full_busy", 32'(o_busy), 32'd0);
      check("full_done", 32'(o_done), 32'd1);
      repeat (3) step();
      check("done_hold", 32'(o_done), 32'd1);
      for (int a = 0; a < 9; a++) begin
         i_rd_addr = NB_ADDR'(a);
         step();
         check($sformatf("cap_bit0[%0d]", a), 32'(o_rd_data[0]), 32'd1);
      end
      for (int a = 0; a < DEPTH; a++) read_check(a, exp_mem[a], "cap_word");

      // Abort after 5 writes; older words beyond address 4 stay in RAM.
      capture(5);
      i_enable = 4'b0011;
      step();
      check("abort_busy", 32'(o_busy), 32'd0);
      check("abort_done", 32'(o_done), 32'd0);
      repeat (2) step();
      check("abort_idle_busy", 32'(o_busy), 32'd0);
      for (int a = 0; a < DEPTH; a++) read_check(a, exp_mem[a], "abort_word");

      // Restart must write from address 0 and fill all 16 words.
      i_enable = 4'b0111;
      capture(DEPTH);
      check("restart_done", 32'(o_done), 32'd1);
      for (int a = 0; a < DEPTH; a++) read_check(a, exp_mem[a], "restart_word");

      // Reset after 4 writes of a new capture.
      capture(4);
      i_reset = 1'b1;
      step();
      check("mid_rst_data",  32'(o_data),    32'd0);
      check("mid_rst_valid", 32'(o_valid),   32'd0);
      check("mid_rst_busy",  32'(o_busy),    32'd0);
      check("mid_rst_done",  32'(o_done),    32'd0);
      check("mid_rst_rd",    32'(o_rd_data), 32'd0);
      i_reset  = 1'b0;
      i_enable = 4'b0000;
      for (int a = 0; a < DEPTH; a++) read_check(a, exp_mem[a], "retained_word");
      i_rate   = 3'd0;
      i_enable = 4'b0011;
      for (int e = 0; e < 9; e++) begin
         step();
         check($sformatf("reseed_valid%0d", e), 32'(o_valid),   32'd1);
         check($sformatf("reseed_ch0_%0d", e),  32'(o_data[0]), 32'd1);
      end
      check("reseed_busy", 32'(o_busy), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/tx_prbs_capture.md
Name: tx_prbs_capture

Overview:
- Parametrised multi-channel PRBS transmitter front-end with a programmable rate divider and an on-chip capture buffer.
- Generates NUM_CH independent PRBS9 bit streams, each with its own seed, and advances them on a programmable strobe.
- Capture FSM records CAPTURE_DEPTH consecutive valid samples into internal RAM for later read-back by the debug/readout logic.
- Feeds downstream per-channel FIR filters via o_data/o_valid.

Parameters:
- NB_COUNT, 3, width of rate divider counter and i_rate.
- NUM_CH, 4, number of PRBS channels (1..16).
- CAPTURE_DEPTH, 1024, capture RAM words; power of two.
- NB_ADDR, 10, log2(CAPTURE_DEPTH).

Ports:
- clock  in  1  system clock; all logic on rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_enable  in  4  [0] divider run, [1] PRBS advance, [2] capture allow, [3] unused (LED only).
- i_rate  in  NB_COUNT  strobe period minus one.
- i_start  in  1  capture start request, sampled each cycle.
- i_rd_addr  in  NB_ADDR  capture RAM read address.
- o_leds  out  4  equals i_enable, combinational.
- o_data  out  NUM_CH  current PRBS bit per channel, registered.
- o_valid  out  1  one-cycle strobe qualifying o_data.
- o_busy  out  1  capture in progress.
- o_done  out  1  capture buffer full and valid.
- o_rd_data  out  NUM_CH  RAM word at i_rd_addr, 1-cycle latency.

Behaviour:
- Reset (clock edge with i_reset=1):
  - count=0.
  - LFSR[c]=SEED(c).
  - o_data=0, o_valid=0, o_rd_data=0, o_busy=0, o_done=0.
  - FSM=IDLE, wr_addr=0.
  - RAM contents not cleared.
- Divider:
  - Internal tick = i_enable[0] && (count >= i_rate).
  - On tick: count<=0. Else if i_enable[0]: count<=count+1. Else count holds.
  - i_rate=0 gives a tick every enabled cycle.
  - Lowering i_rate below the current count gives a tick on the next enabled cycle (>= compare, no wrap-around gap).
- PRBS per channel:
  - Polynomial x^9+x^5+1; 9-bit register r.
  - Advance = tick && i_enable[1]. On advance:
    - o_data[c] <= r[8].
    - r <= {r[7:0], r[8]^r[4]}.
  - If r==0 is ever detected, reload SEED(c) on the next cycle (lock-up guard).
  - o_valid <= advance, so o_valid is high in the same cycle the new o_data is visible.
  - Without an advance, o_data holds and o_valid=0.
  - Sequence period is 511.
- Capture FSM, states IDLE, CAPTURE, DONE:
  - IDLE: i_start && i_enable[2] -> CAPTURE; wr_addr<=0, o_busy<=1.
  - CAPTURE, each cycle with o_valid=1:
    - mem[wr_addr] <= o_data.
    - wr_addr <= wr_addr+1.
    - The write at wr_addr == CAPTURE_DEPTH-1 -> DONE; o_busy<=0, o_done<=1.
  - CAPTURE, i_enable[2] falls: abort -> IDLE; o_busy<=0, o_done stays 0, wr_addr<=0. Partial data is left in RAM.
  - CAPTURE, i_start is ignored.
  - DONE: o_done holds. i_start && i_enable[2] -> CAPTURE; o_done<=0, o_busy<=1, wr_addr<=0.
  - Reset in any state -> IDLE, with RAM contents retained.
- Read port:
  - o_rd_data <= mem[i_rd_addr] every cycle (read-first).
  - A simultaneous write to the same address returns the old word.
  - Valid in any state.

Decomposition:
- Shared package tx_pkg:
  - PRBS_ORDER=9 and tap positions 8 and 4.
  - SEED(c) function = 9'h1FF ^ (c<<1), always non-zero.
  - FSM state encoding for IDLE/CAPTURE/DONE.
- One sub-module, prbs_lfsr: a single channel with seed parameter, advance input and bit output; instantiated NUM_CH times via generate.
- Divider, FSM and RAM (inferred single-port write, registered read) live in the top.

Test Plan:
- Rate 3: i_rate=3, i_enable=4'b0011 -> o_valid every 4th cycle. Channel 0 first 9 o_data bits all 1; ch1 differs from ch0 within the first 9 strobes.
- Rate 0 and dynamic change: i_rate=0 -> o_valid every cycle. i_rate=7, then at count=5 switch to 2 -> tick on the next cycle, then every 3 cycles.
- Capture with CAPTURE_DEPTH=16, NB_ADDR=4, i_rate=0, i_enable=4'b0111, pulse i_start:
  - o_busy high for 16 valids, then o_done=1.
  - Reading addr 0..8 gives bit0=1.
  - Captured words equal the monitored o_data stream.
- Abort: drop i_enable[2] after 5 writes -> IDLE, o_busy=0, o_done=0. Re-start -> writes restart at addr 0.
- Enable gating: i_enable[1]=0 with the divider running -> o_valid=0, o_data frozen. i_enable[0]=0 -> count frozen. o_leds tracks i_enable.
- Reset mid-capture: assert i_reset for 1 cycle -> all outputs 0, FSM IDLE, LFSR reseeded (ch0 again emits 9 ones), previously written RAM words still readable.
